// File: rtl/id_ex_stage_if.sv
// rtl/id_ex_stage_if.sv - decode, forwarding and EX-slot signals of the ID/EX stage
interface id_ex_stage_if #(
    parameter int XLEN = 32,
    parameter int REGW = 5
);
    logic            id_valid;
    logic [XLEN-1:0] id_pc;
    logic [REGW-1:0] id_rs1;
    logic [REGW-1:0] id_rs2;
    logic [REGW-1:0] id_rd;
    logic [XLEN-1:0] id_rs1_data;
    logic [XLEN-1:0] id_rs2_data;
    logic [XLEN-1:0] id_imm;
    logic            id_use_imm;
    logic [3:0]      id_alu_op;
    logic            id_reg_wr;
    logic            id_mem_rd;
    logic            id_mem_wr;
    logic [XLEN-1:0] alu_result;
    logic [REGW-1:0] wb_rd;
    logic            wb_reg_wr;
    logic [XLEN-1:0] wb_data;
    logic            hold;
    logic            flush;
    logic            id_stall;
    logic            ex_valid;
    logic [XLEN-1:0] ex_a;
    logic [XLEN-1:0] ex_b;
    logic [3:0]      ex_alu_op;
    logic [REGW-1:0] ex_rd;
    logic            ex_reg_wr;
    logic            ex_mem_rd;
    logic            ex_mem_wr;
    logic [XLEN-1:0] ex_store_data;
    logic [XLEN-1:0] ex_pc;
    logic [XLEN-1:0] ex_imm;

    modport master (
        output id_valid, id_pc, id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data,
               id_imm, id_use_imm, id_alu_op, id_reg_wr, id_mem_rd, id_mem_wr,
               alu_result, wb_rd, wb_reg_wr, wb_data, hold, flush,
        input  id_stall, ex_valid, ex_a, ex_b, ex_alu_op, ex_rd, ex_reg_wr,
               ex_mem_rd, ex_mem_wr, ex_store_data, ex_pc, ex_imm
    );

    modport slave (
        input  id_valid, id_pc, id_rs1, id_rs2, id_rd, id_rs1_data, id_rs2_data,
               id_imm, id_use_imm, id_alu_op, id_reg_wr, id_mem_rd, id_mem_wr,
               alu_result, wb_rd, wb_reg_wr, wb_data, hold, flush,
        output id_stall, ex_valid, ex_a, ex_b, ex_alu_op, ex_rd, ex_reg_wr,
               ex_mem_rd, ex_mem_wr, ex_store_data, ex_pc, ex_imm
    );
endinterface

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with operand forwarding and load-use bubbles
module id_ex_stage #(
    parameter int XLEN = 32,
    parameter int REGW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    id_ex_stage_if.slave  bus
);
    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [3:0]      alu_op;
        logic [REGW-1:0] rd;
        logic            reg_wr;
        logic            mem_rd;
        logic            mem_wr;
        logic [XLEN-1:0] store_data;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
    } ex_slot_t;

    ex_slot_t ex_q;
    ex_slot_t ex_d;

    logic [XLEN-1:0] fwd_rs1;
    logic [XLEN-1:0] fwd_rs2;
    logic            load_use;

    // A load in EX has no result yet, so it is never a forwarding source.
    function automatic logic [XLEN-1:0] fwd_sel(
        input logic [REGW-1:0] rs,
        input logic [XLEN-1:0] rf_data,
        input ex_slot_t        ex,
        input logic [XLEN-1:0] alu_res,
        input logic            wb_wr,
        input logic [REGW-1:0] wb_idx,
        input logic [XLEN-1:0] wb_val
    );
        logic [XLEN-1:0] v;
        v = rf_data;
        if (rs == '0)
            v = '0;
        else if (ex.valid && ex.reg_wr && !ex.mem_rd && ex.rd == rs)
            v = alu_res;
        else if (wb_wr && wb_idx == rs)
            v = wb_val;
        return v;
    endfunction

    always_comb begin
        fwd_rs1 = fwd_sel(bus.id_rs1, bus.id_rs1_data, ex_q, bus.alu_result,
                          bus.wb_reg_wr, bus.wb_rd, bus.wb_data);
        fwd_rs2 = fwd_sel(bus.id_rs2, bus.id_rs2_data, ex_q, bus.alu_result,
                          bus.wb_reg_wr, bus.wb_rd, bus.wb_data);
    end

    // rs2 only matters when it feeds operand b or store data.
    assign load_use = bus.id_valid && ex_q.valid && ex_q.mem_rd && (ex_q.rd != '0) &&
                      ((ex_q.rd == bus.id_rs1) ||
                       ((ex_q.rd == bus.id_rs2) && (!bus.id_use_imm || bus.id_mem_wr)));

    assign bus.id_stall = bus.hold || (load_use && !bus.flush);

    always_comb begin
        ex_d = ex_q;
        if (bus.flush) begin
            ex_d = '0;
        end else if (bus.hold) begin
            ex_d = ex_q;
        end else if (load_use || !bus.id_valid) begin
            ex_d = '0;
        end else begin
            ex_d.valid      = 1'b1;
            ex_d.a          = fwd_rs1;
            ex_d.b          = bus.id_use_imm ? bus.id_imm : fwd_rs2;
            ex_d.alu_op     = bus.id_alu_op;
            ex_d.rd         = bus.id_rd;
            ex_d.reg_wr     = bus.id_reg_wr;
            ex_d.mem_rd     = bus.id_mem_rd;
            ex_d.mem_wr     = bus.id_mem_wr;
            ex_d.store_data = fwd_rs2;
            ex_d.pc         = bus.id_pc;
            ex_d.imm        = bus.id_imm;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ex_q <= '0;
        else
            ex_q <= ex_d;
    end

    assign bus.ex_valid      = ex_q.valid;
    assign bus.ex_a          = ex_q.a;
    assign bus.ex_b          = ex_q.b;
    assign bus.ex_alu_op     = ex_q.alu_op;
    assign bus.ex_rd         = ex_q.rd;
    assign bus.ex_reg_wr     = ex_q.reg_wr;
    assign bus.ex_mem_rd     = ex_q.mem_rd;
    assign bus.ex_mem_wr     = ex_q.mem_wr;
    assign bus.ex_store_data = ex_q.store_data;
    assign bus.ex_pc         = ex_q.pc;
    assign bus.ex_imm        = ex_q.imm;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - directed bench for id_ex_stage
module tb_id_ex_stage;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fails;

    id_ex_stage_if #(.XLEN(32), .REGW(5)) bus ();

    id_ex_stage #(.XLEN(32), .REGW(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic decode(input logic [4:0] rs1, input logic [31:0] d1,
                          input logic [4:0] rs2, input logic [31:0] d2,
                          input logic [4:0] rd, input logic use_imm, input logic [31:0] imm,
                          input logic [3:0] op, input logic rw, input logic mr, input logic mw);
        bus.id_valid    = 1'b1;
        bus.id_rs1      = rs1;
        bus.id_rs1_data = d1;
        bus.id_rs2      = rs2;
        bus.id_rs2_data = d2;
        bus.id_rd       = rd;
        bus.id_use_imm  = use_imm;
        bus.id_imm      = imm;
        bus.id_alu_op   = op;
        bus.id_reg_wr   = rw;
        bus.id_mem_rd   = mr;
        bus.id_mem_wr   = mw;
    endtask

    task automatic wb(input logic en, input logic [4:0] rd, input logic [31:0] d);
        bus.wb_reg_wr = en;
        bus.wb_rd     = rd;
        bus.wb_data   = d;
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        rst_n = 1'b0;
        bus.id_valid = 1'b0; bus.id_pc = 32'h0; bus.id_rs1 = '0; bus.id_rs2 = '0;
        bus.id_rd = '0; bus.id_rs1_data = '0; bus.id_rs2_data = '0; bus.id_imm = '0;
        bus.id_use_imm = 1'b0; bus.id_alu_op = 4'h0; bus.id_reg_wr = 1'b0;
        bus.id_mem_rd = 1'b0; bus.id_mem_wr = 1'b0; bus.alu_result = '0;
        bus.wb_rd = '0; bus.wb_reg_wr = 1'b0; bus.wb_data = '0;
        bus.hold = 1'b0; bus.flush = 1'b0;
        step();
        check("reset_valid", {31'b0, bus.ex_valid}, 32'd0);
        check("reset_a", bus.ex_a, 32'd0);
        check("reset_stall", {31'b0, bus.id_stall}, 32'd0);
        rst_n = 1'b1;

        // ADD x3 = x1 + x2
        decode(5'd1, 32'd5, 5'd2, 32'd7, 5'd3, 1'b0, 32'd0, 4'h0, 1'b1, 1'b0, 1'b0);
        bus.id_pc = 32'h100;
        check("add_stall", {31'b0, bus.id_stall}, 32'd0);
        step();
        check("add_valid", {31'b0, bus.ex_valid}, 32'd1);
        check("add_a", bus.ex_a, 32'd5);
        check("add_b", bus.ex_b, 32'd7);
        check("add_op", {28'b0, bus.ex_alu_op}, 32'd0);
        check("add_rd", {27'b0, bus.ex_rd}, 32'd3);
        check("add_pc", bus.ex_pc, 32'h100);

        // EX writes x3 (0x10), WB writes x3 (0x99): EX wins
        bus.alu_result = 32'h10;
        wb(1'b1, 5'd3, 32'h99);
        decode(5'd3, 32'h11, 5'd3, 32'h22, 5'd6, 1'b1, 32'h44, 4'h2, 1'b1, 1'b0, 1'b0);
        step();
        check("fwd_ex_a", bus.ex_a, 32'h10);
        check("fwd_ex_b_imm", bus.ex_b, 32'h44);
        check("fwd_ex_store", bus.ex_store_data, 32'h10);
        check("fwd_ex_op", {28'b0, bus.ex_alu_op}, 32'd2);

        // WB-only forward on rs1; rf data on rs2; writes x0
        decode(5'd3, 32'h11, 5'd7, 32'h77, 5'd0, 1'b0, 32'd0, 4'h0, 1'b1, 1'b0, 1'b0);
        step();
        check("fwd_wb_a", bus.ex_a, 32'h99);
        check("rf_b", bus.ex_b, 32'h77);

        // x0 is never forwarded, even with EX and WB both targeting x0; also LW x4
        wb(1'b1, 5'd0, 32'h99);
        decode(5'd0, 32'h55, 5'd0, 32'h66, 5'd4, 1'b1, 32'd8, 4'h0, 1'b1, 1'b1, 1'b0);
        step();
        check("x0_a", bus.ex_a, 32'd0);
        check("x0_store", bus.ex_store_data, 32'd0);
        check("lw_b", bus.ex_b, 32'd8);
        check("lw_mem_rd", {31'b0, bus.ex_mem_rd}, 32'd1);

        // load-use: ADD x7 = x4 + x1
        wb(1'b0, 5'd0, 32'd0);
        bus.alu_result = 32'hDEAD;
        decode(5'd4, 32'h1234, 5'd1, 32'd5, 5'd7, 1'b0, 32'd0, 4'h0, 1'b1, 1'b0, 1'b0);
        #1;
        check("lu_stall", {31'b0, bus.id_stall}, 32'd1);
        step();
        check("lu_bubble_valid", {31'b0, bus.ex_valid}, 32'd0);
        check("lu_bubble_a", bus.ex_a, 32'd0);
        check("lu_bubble_mem_rd", {31'b0, bus.ex_mem_rd}, 32'd0);
        wb(1'b1, 5'd4, 32'hABCD);
        #1;
        check("lu_stall_clear", {31'b0, bus.id_stall}, 32'd0);
        step();
        check("lu_recap_valid", {31'b0, bus.ex_valid}, 32'd1);
        check("lu_recap_a", bus.ex_a, 32'hABCD);
        check("lu_recap_b", bus.ex_b, 32'd5);
        check("lu_recap_rd", {27'b0, bus.ex_rd}, 32'd7);

        // LW x8, then ADDI with rs2 field = x8: no stall
        wb(1'b0, 5'd0, 32'd0);
        decode(5'd1, 32'd5, 5'd0, 32'd0, 5'd8, 1'b1, 32'd4, 4'h0, 1'b1, 1'b1, 1'b0);
        step();
        decode(5'd1, 32'd5, 5'd8, 32'd0, 5'd9, 1'b1, 32'd3, 4'h0, 1'b1, 1'b0, 1'b0);
        #1;
        check("addi_no_stall", {31'b0, bus.id_stall}, 32'd0);
        step();
        check("addi_valid", {31'b0, bus.ex_valid}, 32'd1);
        check("addi_b", bus.ex_b, 32'd3);

        // LW x8, then SW x8 -> 0x20(x1): stall on rs2
        decode(5'd1, 32'd5, 5'd0, 32'd0, 5'd8, 1'b1, 32'd4, 4'h0, 1'b1, 1'b1, 1'b0);
        step();
        decode(5'd1, 32'd5, 5'd8, 32'd0, 5'd0, 1'b1, 32'h20, 4'h0, 1'b0, 1'b0, 1'b1);
        #1;
        check("sw_stall", {31'b0, bus.id_stall}, 32'd1);
        step();
        check("sw_bubble", {31'b0, bus.ex_valid}, 32'd0);
        wb(1'b1, 5'd8, 32'h5A);
        step();
        check("sw_valid", {31'b0, bus.ex_valid}, 32'd1);
        check("sw_store", bus.ex_store_data, 32'h5A);
        check("sw_b", bus.ex_b, 32'h20);
        check("sw_mem_wr", {31'b0, bus.ex_mem_wr}, 32'd1);

        // hold for 3 cycles: EX slot frozen
        wb(1'b0, 5'd0, 32'd0);
        decode(5'd1, 32'd5, 5'd2, 32'd7, 5'd10, 1'b0, 32'd0, 4'h0, 1'b1, 1'b0, 1'b0);
        bus.hold = 1'b1;
        #1;
        check("hold_stall", {31'b0, bus.id_stall}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("hold_valid", {31'b0, bus.ex_valid}, 32'd1);
            check("hold_store", bus.ex_store_data, 32'h5A);
            check("hold_rd", {27'b0, bus.ex_rd}, 32'd0);
        end
        bus.flush = 1'b1;
        #1;
        check("hold_flush_stall", {31'b0, bus.id_stall}, 32'd1);
        step();
        check("flush_valid", {31'b0, bus.ex_valid}, 32'd0);
        check("flush_mem_wr", {31'b0, bus.ex_mem_wr}, 32'd0);
        check("flush_b", bus.ex_b, 32'd0);
        bus.hold = 1'b0;
        bus.flush = 1'b0;
        step();
        check("post_flush_valid", {31'b0, bus.ex_valid}, 32'd1);
        check("post_flush_a", bus.ex_a, 32'd5);
        check("post_flush_rd", {27'b0, bus.ex_rd}, 32'd10);

        // empty decode slot -> bubble
        bus.id_valid = 1'b0;
        step();
        check("idle_valid", {31'b0, bus.ex_valid}, 32'd0);
        check("idle_reg_wr", {31'b0, bus.ex_reg_wr}, 32'd0);
        bus.id_valid = 1'b1;
        step();
        check("recap_valid", {31'b0, bus.ex_valid}, 32'd1);

        // asynchronous reset between edges
        #2;
        rst_n = 1'b0;
        #1;
        check("areset_valid", {31'b0, bus.ex_valid}, 32'd0);
        check("areset_a", bus.ex_a, 32'd0);
        check("areset_rd", {27'b0, bus.ex_rd}, 32'd0);
        check("areset_stall", {31'b0, bus.id_stall}, 32'd0);
        rst_n = 1'b1;
        step();
        check("post_reset_valid", {31'b0, bus.ex_valid}, 32'd1);
        check("post_reset_b", bus.ex_b, 32'd7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
